// File: rtl/debug_unit_if.sv
// Purpose : groups the UART, instruction-memory, pipeline and register-file
//           debug signals of debug_unit into one bundle.
// Latency : none (wires only).
// Backpressure: none; the UART side uses tx_start/tx_done strobes.
// Ports   : master = debug_unit side, slave = UART/pipeline/memory side.
interface debug_unit_if #(
    parameter int NB_REG             = 32,
    parameter int NB_BYTE            = 8,
    parameter int NB_REG_ADDR        = 5,
    parameter int LOG2_N_INSMEM_ADDR = 10
);
    // UART receive / transmit
    logic [NB_BYTE-1:0]            i_rx_data;
    logic                          i_rx_valid;
    logic [NB_BYTE-1:0]            o_tx_data;
    logic                          o_tx_start;
    logic                          i_tx_done;
    // pipeline control and status
    logic                          o_pipe_valid;
    logic [NB_REG-1:0]             i_pc;
    logic                          i_halt;
    logic [NB_REG-1:0]             o_n_clocks;
    // instruction memory write port
    logic                          o_imem_we;
    logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr;
    logic [NB_REG-1:0]             o_imem_data;
    // register-file debug read port
    logic [NB_REG_ADDR-1:0]        o_rf_addr;
    logic [NB_REG-1:0]             i_rf_data;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_done, i_pc, i_halt, i_rf_data,
        output o_tx_data, o_tx_start, o_pipe_valid, o_n_clocks,
               o_imem_we, o_imem_addr, o_imem_data, o_rf_addr
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_done, i_pc, i_halt, i_rf_data,
        input  o_tx_data, o_tx_start, o_pipe_valid, o_n_clocks,
               o_imem_we, o_imem_addr, o_imem_data, o_rf_addr
    );
endinterface

// File: rtl/debug_unit.sv
// Purpose : UART-driven debug controller: loads instruction memory, runs or
//           single-steps the pipeline, then dumps PC, cycle count and registers.
// Latency : imem write one cycle after the 4th byte; tx_start one cycle per byte.
// Backpressure: each dump byte waits for i_tx_done before the next tx_start.
// Ports   : i_clock / i_reset (async, active low); everything else on bus.
module debug_unit #(
    parameter int NB_REG             = 32,
    parameter int NB_BYTE            = 8,
    parameter int NB_REG_ADDR        = 5,
    parameter int LOG2_N_INSMEM_ADDR = 10
) (
    input  logic         i_clock,
    input  logic         i_reset,
    debug_unit_if.master bus
);
    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h01);
    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h02);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h03);
    localparam logic [7:0]         LAST_DUMP_IDX = 8'd135;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STEP,
        DUMP_SEND,
        DUMP_WAIT
    } state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    byte_cnt_q, byte_cnt_d;
    // Only the first three bytes need storing; the fourth arrives with the write.
    logic [NB_REG-NB_BYTE-1:0]     word_q, word_d;
    logic [LOG2_N_INSMEM_ADDR-1:0] addr_q, addr_d;
    logic [NB_REG-1:0]             n_clocks_q, n_clocks_d;
    logic                          halted_q, halted_d;
    logic [7:0]                    dump_idx_q, dump_idx_d;
    logic [NB_REG-1:0]             pc_q, pc_d;
    logic                          imem_we_q, imem_we_d;
    logic [LOG2_N_INSMEM_ADDR-1:0] imem_addr_q, imem_addr_d;
    logic [NB_REG-1:0]             imem_data_q, imem_data_d;

    logic                          pipe_valid;
    logic                          tx_start;
    logic [NB_REG-1:0]             full_word;
    logic [5:0]                    word_sel;
    logic [1:0]                    byte_sel;
    logic [NB_REG-1:0]             dump_word;
    logic [NB_BYTE-1:0]            tx_byte;
    logic [NB_REG_ADDR-1:0]        rf_addr;

    assign full_word = {word_q, bus.i_rx_data};
    assign word_sel  = dump_idx_q[7:2];
    assign byte_sel  = dump_idx_q[1:0];

    // Dump layout: word 0 = PC, word 1 = cycle count, words 2..33 = registers.
    always_comb begin
        rf_addr   = '0;
        dump_word = bus.i_rf_data;
        if (word_sel == 6'd0) begin
            dump_word = pc_q;
        end else if (word_sel == 6'd1) begin
            dump_word = n_clocks_q;
        end else begin
            rf_addr = NB_REG_ADDR'(word_sel - 6'd2);
        end
    end

    // MSB-first byte select within the current dump word.
    always_comb begin
        tx_byte = '0;
        case (byte_sel)
            2'd0:    tx_byte = dump_word[4*NB_BYTE-1 -: NB_BYTE];
            2'd1:    tx_byte = dump_word[3*NB_BYTE-1 -: NB_BYTE];
            2'd2:    tx_byte = dump_word[2*NB_BYTE-1 -: NB_BYTE];
            default: tx_byte = dump_word[NB_BYTE-1   -: NB_BYTE];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        addr_d      = addr_q;
        halted_d    = halted_q;
        dump_idx_d  = dump_idx_q;
        pc_d        = pc_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        pipe_valid  = 1'b0;
        tx_start    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == CMD_LOAD) begin
                        state_d    = LOAD;
                        byte_cnt_d = '0;
                        addr_d     = '0;
                        halted_d   = 1'b0;
                    end else if (bus.i_rx_data == CMD_RUN ||
                                 bus.i_rx_data == CMD_STEP) begin
                        // A halted pipeline must not advance again; just report.
                        if (halted_q) begin
                            state_d    = DUMP_SEND;
                            pc_d       = bus.i_pc;
                            dump_idx_d = '0;
                        end else begin
                            state_d = (bus.i_rx_data == CMD_RUN) ? RUN : STEP;
                        end
                    end
                end
            end
            LOAD: begin
                if (bus.i_rx_valid) begin
                    word_d = {word_q[NB_REG-2*NB_BYTE-1:0], bus.i_rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d  = '0;
                        imem_we_d   = 1'b1;
                        imem_addr_d = addr_q;
                        imem_data_d = full_word;
                        addr_d      = addr_q + 1'b1;
                        if (full_word == '1) begin
                            state_d = IDLE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            RUN: begin
                pipe_valid = 1'b1;
                if (bus.i_halt) begin
                    halted_d   = 1'b1;
                    state_d    = DUMP_SEND;
                    pc_d       = bus.i_pc;
                    dump_idx_d = '0;
                end
            end
            STEP: begin
                pipe_valid = 1'b1;
                if (bus.i_halt) begin
                    halted_d = 1'b1;
                end
                state_d    = DUMP_SEND;
                pc_d       = bus.i_pc;
                dump_idx_d = '0;
            end
            DUMP_SEND: begin
                tx_start = 1'b1;
                state_d  = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (bus.i_tx_done) begin
                    if (dump_idx_q == LAST_DUMP_IDX) begin
                        dump_idx_d = '0;
                        state_d    = IDLE;
                    end else begin
                        dump_idx_d = dump_idx_q + 8'd1;
                        state_d    = DUMP_SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The load command restarts the cycle count; otherwise count enabled cycles.
    always_comb begin
        n_clocks_d = n_clocks_q + (pipe_valid ? NB_REG'(1) : NB_REG'(0));
        if (state_q == IDLE && bus.i_rx_valid && bus.i_rx_data == CMD_LOAD) begin
            n_clocks_d = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            n_clocks_q  <= '0;
            halted_q    <= 1'b0;
            dump_idx_q  <= '0;
            pc_q        <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            n_clocks_q  <= n_clocks_d;
            halted_q    <= halted_d;
            dump_idx_q  <= dump_idx_d;
            pc_q        <= pc_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
        end
    end

    assign bus.o_pipe_valid = pipe_valid;
    assign bus.o_tx_start   = tx_start;
    assign bus.o_tx_data    = tx_byte;
    assign bus.o_rf_addr    = rf_addr;
    assign bus.o_n_clocks   = n_clocks_q;
    assign bus.o_imem_we    = imem_we_q;
    assign bus.o_imem_addr  = imem_addr_q;
    assign bus.o_imem_data  = imem_data_q;
endmodule

// File: tb/tb_debug_unit.sv
// Purpose : directed self-checking bench for debug_unit (load, step, run,
//           ignore, reset and address-wrap scenarios).
// Latency : n/a.  Backpressure: a small UART model answers each tx_start.
module tb_debug_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_unit_if #(.NB_REG(32), .NB_BYTE(8), .NB_REG_ADDR(5), .LOG2_N_INSMEM_ADDR(10)) bus();

    debug_unit #(.NB_REG(32), .NB_BYTE(8), .NB_REG_ADDR(5), .LOG2_N_INSMEM_ADDR(10)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    // Register r reads as A5 r 5A ~r.
    assign bus.i_rf_data = {8'hA5, 3'b000, bus.o_rf_addr, 8'h5A, ~{3'b000, bus.o_rf_addr}};

    int n_checks = 0;
    int n_fail   = 0;
    int pv_cnt   = 0;
    int excl_err = 0;
    int tx_overlap  = 0;
    int tx_unstable = 0;
    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  dump_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Output monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.o_pipe_valid) pv_cnt++;
        if (bus.o_imem_we) begin
            wr_addr_q.push_back(bus.o_imem_addr);
            wr_data_q.push_back(bus.o_imem_data);
        end
        if (int'(bus.o_imem_we) + int'(bus.o_tx_start) + int'(bus.o_pipe_valid) > 1)
            excl_err++;
    end

    // UART transmitter model: takes a byte on tx_start, answers tx_done later.
    initial begin
        logic [7:0] b;
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_tx_done = 1'b0;
            if (bus.o_tx_start) begin
                b = bus.o_tx_data;
                dump_q.push_back(b);
                repeat (2) begin
                    @(negedge clk);
                    if (bus.o_tx_start) tx_overlap++;
                    if (bus.o_tx_data !== b) tx_unstable++;
                end
                bus.i_tx_done = 1'b1;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pc,
                                            input logic [31:0] nclk);
        logic [31:0] w;
        logic [4:0]  r;
        int          wi;
        wi = i / 4;
        r  = 5'(wi - 2);
        if (wi == 0)      w = pc;
        else if (wi == 1) w = nclk;
        else              w = {8'hA5, 3'b000, r, 8'h5A, ~{3'b000, r}};
        return w[(3 - (i % 4))*8 +: 8];
    endfunction

    // Waits (bounded) for a full dump starting at queue index s and checks it.
    task automatic check_dump(input string tag, input int s, input logic [31:0] pc,
                              input logic [31:0] nclk);
        int t;
        int bad;
        logic [31:0] got_nclk;
        t = 0;
        while (dump_q.size() < s + 136 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (12) @(negedge clk);
        chk({tag, "_len"}, 32'(dump_q.size() - s), 32'd136);
        bad = 0;
        got_nclk = '0;
        for (int i = 0; i < 136; i++) begin
            if (s + i >= dump_q.size()) bad++;
            else if (dump_q[s+i] !== exp_byte(i, pc, nclk)) bad++;
        end
        chk({tag, "_bad_bytes"}, 32'(bad), 32'd0);
        if (dump_q.size() >= s + 8)
            got_nclk = {dump_q[s+4], dump_q[s+5], dump_q[s+6], dump_q[s+7]};
        chk({tag, "_nclk_bytes"}, got_nclk, nclk);
    endtask

    function automatic logic [31:0] wr_addr_at(input int i);
        return (i < wr_addr_q.size()) ? 32'(wr_addr_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wr_data_at(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int w0, pv0, d0;
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_pc       = '0;
        bus.i_halt     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_imem_we", 32'(bus.o_imem_we), 32'd0);
        chk("rst_pipe_valid", 32'(bus.o_pipe_valid), 32'd0);
        chk("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
        chk("rst_n_clocks", bus.o_n_clocks, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unknown command in IDLE is ignored
        w0 = wr_addr_q.size(); pv0 = pv_cnt; d0 = dump_q.size();
        send_byte(8'h55);
        repeat (5) @(negedge clk);
        chk("ign55_we", 32'(wr_addr_q.size() - w0), 32'd0);
        chk("ign55_pv", 32'(pv_cnt - pv0), 32'd0);
        chk("ign55_tx", 32'(dump_q.size() - d0), 32'd0);

        // Load two words, the second is the halt word
        w0 = wr_addr_q.size();
        send_byte(8'h01);
        send_word(32'h208C_0004);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        chk("load_cnt", 32'(wr_addr_q.size() - w0), 32'd2);
        chk("load_addr0", wr_addr_at(w0), 32'd0);
        chk("load_data0", wr_data_at(w0), 32'h208C_0004);
        chk("load_addr1", wr_addr_at(w0+1), 32'd1);
        chk("load_data1", wr_data_at(w0+1), 32'hFFFF_FFFF);

        // Single step
        bus.i_pc = 32'h1234_5678;
        pv0 = pv_cnt; d0 = dump_q.size();
        send_byte(8'h03);
        repeat (3) @(negedge clk);
        bus.i_pc = 32'hDEAD_0000;
        check_dump("step", d0, 32'h1234_5678, 32'd1);
        chk("step_pv", 32'(pv_cnt - pv0), 32'd1);
        chk("step_nclk", bus.o_n_clocks, 32'd1);

        // Reload to restart the cycle count
        send_byte(8'h01);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        chk("reload_nclk", bus.o_n_clocks, 32'd0);

        // Run with halt on the 10th enabled cycle
        bus.i_pc = 32'h0000_0100;
        pv0 = pv_cnt; d0 = dump_q.size();
        send_byte(8'h02);
        repeat (9) @(negedge clk);
        bus.i_halt = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_pc = 32'hBAD0_0000;
        check_dump("run", d0, 32'h0000_0100, 32'd10);
        chk("run_pv", 32'(pv_cnt - pv0), 32'd10);
        chk("run_nclk", bus.o_n_clocks, 32'd10);
        bus.i_halt = 1'b0;

        // Run while halted: dump only; a load command mid-dump is ignored
        bus.i_pc = 32'h0000_0200;
        pv0 = pv_cnt; d0 = dump_q.size(); w0 = wr_addr_q.size();
        send_byte(8'h02);
        repeat (20) @(negedge clk);
        send_byte(8'h01);
        bus.i_pc = 32'hBAD0_0001;
        check_dump("rerun", d0, 32'h0000_0200, 32'd10);
        chk("rerun_pv", 32'(pv_cnt - pv0), 32'd0);
        chk("rerun_we", 32'(wr_addr_q.size() - w0), 32'd0);
        chk("rerun_nclk", bus.o_n_clocks, 32'd10);

        // Step while halted: dump only
        bus.i_pc = 32'h0000_0300;
        pv0 = pv_cnt; d0 = dump_q.size();
        send_byte(8'h03);
        check_dump("restep", d0, 32'h0000_0300, 32'd10);
        chk("restep_pv", 32'(pv_cnt - pv0), 32'd0);

        // Asynchronous reset in the middle of a load word
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(bus.o_imem_we), 32'd0);
        chk("arst_pv", 32'(bus.o_pipe_valid), 32'd0);
        chk("arst_txs", 32'(bus.o_tx_start), 32'd0);
        chk("arst_nclk", bus.o_n_clocks, 32'd0);
        chk("arst_iaddr", 32'(bus.o_imem_addr), 32'd0);
        chk("arst_idata", bus.o_imem_data, 32'd0);
        chk("arst_txd", 32'(bus.o_tx_data), 32'd0);
        chk("arst_rfaddr", 32'(bus.o_rf_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_addr_q.size();
        send_byte(8'h01);
        send_word(32'h1122_3344);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        chk("post_rst_cnt", 32'(wr_addr_q.size() - w0), 32'd2);
        chk("post_rst_addr", wr_addr_at(w0), 32'd0);
        chk("post_rst_data", wr_data_at(w0), 32'h1122_3344);

        // Address wrap: 1025 words then halt
        w0 = wr_addr_q.size();
        send_byte(8'h01);
        for (int i = 0; i < 1025; i++) send_word(32'h0A00_0000 + 32'(i));
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        chk("wrap_cnt", 32'(wr_addr_q.size() - w0), 32'd1026);
        chk("wrap_addr1023", wr_addr_at(w0+1023), 32'd1023);
        chk("wrap_addr1024", wr_addr_at(w0+1024), 32'd0);
        chk("wrap_data1024", wr_data_at(w0+1024), 32'h0A00_0400);
        chk("wrap_halt_addr", wr_addr_at(w0+1025), 32'd1);

        // Global properties
        chk("strobe_exclusive", 32'(excl_err), 32'd0);
        chk("tx_overlap", 32'(tx_overlap), 32'd0);
        chk("tx_stable", 32'(tx_unstable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 The block SHALL have parameter NB_REG, default 32, meaning pipeline data and instruction word width.
REQ-002 The block SHALL have parameter NB_BYTE, default 8, meaning UART byte width.
REQ-003 The block SHALL have parameter NB_REG_ADDR, default 5, meaning register-file address width.
REQ-004 The block SHALL have parameter LOG2_N_INSMEM_ADDR, default 10, meaning instruction-memory address width.
REQ-005 The block SHALL have port i_clock  input  1  single system clock; all state SHALL change on its rising edge.
REQ-006 The block SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port i_rx_data  input  NB_BYTE  received UART byte.
REQ-008 The block SHALL have port i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data.
REQ-009 The block SHALL have port o_tx_data  output  NB_BYTE  byte to transmit.
REQ-010 The block SHALL have port o_tx_start  output  1  one-cycle strobe requesting transmission of o_tx_data.
REQ-011 The block SHALL have port i_tx_done  input  1  one-cycle strobe indicating the transmitter has finished the current byte.
REQ-012 The block SHALL have port o_pipe_valid  output  1  pipeline advance enable, driving the pipeline i_valid.
REQ-013 The block SHALL have port o_imem_we  output  1  instruction-memory write enable.
REQ-014 The block SHALL have port o_imem_addr  output  LOG2_N_INSMEM_ADDR  instruction-memory word address.
REQ-015 The block SHALL have port o_imem_data  output  NB_REG  instruction word to write.
REQ-016 The block SHALL have port i_pc  input  NB_REG  current pipeline PC.
REQ-017 The block SHALL have port i_halt  input  1  high while a halt instruction has reached the end of the pipeline.
REQ-018 The block SHALL have port o_rf_addr  output  NB_REG_ADDR  register-file debug read address.
REQ-019 The block SHALL have port i_rf_data  input  NB_REG  combinational register-file read data for o_rf_addr.
REQ-020 The block SHALL have port o_n_clocks  output  NB_REG  count of cycles with o_pipe_valid high.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, RUN, STEP, DUMP_SEND and DUMP_WAIT.
REQ-022 In IDLE, an i_rx_valid with byte 0x01 SHALL transition to LOAD, clear the address, clear o_n_clocks and clear the halted flag.
REQ-023 In IDLE, an i_rx_valid with byte 0x02 SHALL transition to RUN.
REQ-024 In IDLE, an i_rx_valid with byte 0x03 SHALL transition to STEP.
REQ-025 In IDLE, any other received byte SHALL be ignored.
REQ-026 In LOAD, the block SHALL assemble four received bytes MSB-first into one word.
REQ-027 On the fourth byte, the block SHALL pulse o_imem_we for one cycle with the assembled word on o_imem_data and the current address on o_imem_addr, then increment the address.
REQ-028 The write address SHALL wrap modulo 2^LOG2_N_INSMEM_ADDR.
REQ-029 LOAD SHALL return to IDLE after writing word 0xFFFFFFFF (halt), including that word.
REQ-030 In RUN, o_pipe_valid SHALL be high every cycle until the cycle in which i_halt is sampled high; o_pipe_valid SHALL then go low, the halted flag SHALL be set, and the FSM SHALL go to DUMP_SEND.
REQ-031 In STEP, o_pipe_valid SHALL be high for exactly one cycle; if i_halt is high in that cycle, the halted flag SHALL be set; the FSM SHALL then go to DUMP_SEND.
REQ-032 With the halted flag set, a RUN or STEP command SHALL go directly to DUMP_SEND without asserting o_pipe_valid.
REQ-033 o_n_clocks SHALL increment by 1 in each cycle that o_pipe_valid is high and SHALL wrap modulo 2^NB_REG.
REQ-034 A dump SHALL be exactly 136 bytes, MSB-first per word: i_pc (4 bytes), o_n_clocks (4 bytes), then registers 0..31 (4 bytes each), with o_rf_addr selecting the register being sent.
REQ-035 i_pc SHALL be captured on entry to DUMP_SEND.
REQ-036 In DUMP_SEND, the block SHALL pulse o_tx_start for one cycle with the byte on o_tx_data, then go to DUMP_WAIT.
REQ-037 o_tx_data SHALL be held stable until i_tx_done.
REQ-038 In DUMP_WAIT, i_tx_done SHALL advance the byte index and return the FSM to DUMP_SEND; after byte 135 it SHALL return the FSM to IDLE.
REQ-039 i_rx_valid SHALL be ignored in RUN, STEP, DUMP_SEND and DUMP_WAIT.
REQ-040 i_tx_done outside DUMP_WAIT SHALL be ignored.
REQ-041 o_imem_we, o_tx_start and o_pipe_valid SHALL never be high in the same cycle.

Reset
REQ-042 i_reset low SHALL asynchronously force state IDLE at any point, including mid-LOAD or mid-dump.
REQ-043 i_reset low SHALL clear all outputs, the byte counter, the address, o_n_clocks, the halted flag and the dump index to 0.
REQ-044 On release of i_reset, the block SHALL start in IDLE on the next rising i_clock edge, with no partial word or dump resumed.

Verification
REQ-045 Load test: send 0x01, 20 8C 00 04, FF FF FF FF -> o_imem_we pulses twice: addr 0 data 0x208C0004, then addr 1 data 0xFFFFFFFF; FSM back in IDLE.
REQ-046 Step test: send 0x03 -> o_pipe_valid high 1 cycle, o_n_clocks=1, then 136 o_tx_start pulses, each only after the preceding i_tx_done, with bytes 5..8 = 00 00 00 01.
REQ-047 Run test: send 0x02 with i_halt asserted on the 10th enabled cycle -> o_pipe_valid high for exactly 10 cycles, o_n_clocks=10, dump follows; a subsequent 0x02 -> dump only, o_n_clocks still 10.
REQ-048 Reset test: assert i_reset low after 2 bytes of a LOAD word -> all outputs 0 immediately; after release, 0x01 + 4 bytes writes addr 0.
REQ-049 Ignore test: send 0x55 in IDLE and 0x01 during a dump -> no state change and no spurious o_imem_we.
REQ-050 Wrap test: load 1025 words with LOG2_N_INSMEM_ADDR=10 -> the 1025th word is written to address 0.
